// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU decode/issue stage.
// ALU control codes, MIPS opcode/funct values, skid-buffer state encoding
// and the packed record that travels through the skid buffer.
package alu_issue_pkg;

    // ALU control codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_NOR  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLT  = 4'b1100;
    localparam logic [3:0] ALU_EQ   = 4'b1101;
    localparam logic [3:0] ALU_NONE = 4'b1111;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Skid buffer occupancy
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    // One decoded operation as held in the buffer
    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  sa;
        logic [4:0]  dst;
        logic        is_branch;
        logic        br_inv;
        logic        illegal;
    } alu_op_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zero_ext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational MIPS decoder: opcode/funct to ALU control plus operand select.
// Optional feature macro: ALU_ISSUE_SHIFTV_EN enables sllv/srlv/srav.
module alu_issue_dec
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [3:0]  ctrl,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic [4:0]  sa,
    output logic [4:0]  dst,
    output logic        is_branch,
    output logic        br_inv,
    output logic        illegal
);

    logic [5:0]  opcode_s;
    logic [5:0]  funct_s;
    logic [4:0]  rt_idx_s;
    logic [4:0]  rd_idx_s;
    logic [4:0]  shamt_s;
    logic [15:0] imm_s;
    logic [3:0]  r_ctrl_s;
    logic        r_legal_s;
    logic        r_var_s;
    logic        unused_rs_idx_s;

    assign opcode_s = instr[31:26];
    assign rt_idx_s = instr[20:16];
    assign rd_idx_s = instr[15:11];
    assign shamt_s  = instr[10:6];
    assign funct_s  = instr[5:0];
    assign imm_s    = instr[15:0];
    // rs index is not needed: its value arrives already read as rs_val
    assign unused_rs_idx_s = &{1'b0, instr[25:21]};

    // R-type funct table: control code, legality, and register-sourced shift amount
    always_comb begin
        r_ctrl_s  = ALU_NONE;
        r_legal_s = 1'b0;
        r_var_s   = 1'b0;
        case (funct_s)
            FN_ADD, FN_ADDU: begin r_ctrl_s = ALU_ADD; r_legal_s = 1'b1; end
            FN_SUB, FN_SUBU: begin r_ctrl_s = ALU_SUB; r_legal_s = 1'b1; end
            FN_AND:          begin r_ctrl_s = ALU_AND; r_legal_s = 1'b1; end
            FN_OR:           begin r_ctrl_s = ALU_OR;  r_legal_s = 1'b1; end
            FN_XOR:          begin r_ctrl_s = ALU_XOR; r_legal_s = 1'b1; end
            FN_NOR:          begin r_ctrl_s = ALU_NOR; r_legal_s = 1'b1; end
            FN_SLT:          begin r_ctrl_s = ALU_SLT; r_legal_s = 1'b1; end
            FN_SLL:          begin r_ctrl_s = ALU_SLL; r_legal_s = 1'b1; end
            FN_SRL:          begin r_ctrl_s = ALU_SRL; r_legal_s = 1'b1; end
            FN_SRA:          begin r_ctrl_s = ALU_SRA; r_legal_s = 1'b1; end
`ifdef ALU_ISSUE_SHIFTV_EN
            FN_SLLV: begin r_ctrl_s = ALU_SLL; r_legal_s = 1'b1; r_var_s = 1'b1; end
            FN_SRLV: begin r_ctrl_s = ALU_SRL; r_legal_s = 1'b1; r_var_s = 1'b1; end
            FN_SRAV: begin r_ctrl_s = ALU_SRA; r_legal_s = 1'b1; r_var_s = 1'b1; end
`endif
            default: begin r_ctrl_s = ALU_NONE; r_legal_s = 1'b0; r_var_s = 1'b0; end
        endcase
    end

    // Opcode decode; anything unrecognised falls through as an illegal no-op
    always_comb begin
        ctrl      = ALU_NONE;
        x         = rs_val;
        y         = rt_val;
        sa        = 5'd0;
        dst       = 5'd0;
        is_branch = 1'b0;
        br_inv    = 1'b0;
        illegal   = 1'b1;
        case (opcode_s)
            OP_RTYPE: begin
                if (r_legal_s) begin
                    ctrl    = r_ctrl_s;
                    dst     = rd_idx_s;
                    sa      = r_var_s ? rs_val[4:0] : shamt_s;
                    illegal = 1'b0;
                end else begin
                    ctrl    = ALU_NONE;
                    illegal = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl = ALU_ADD; y = sign_ext16(imm_s); dst = rt_idx_s; illegal = 1'b0;
            end
            OP_SLTI: begin
                ctrl = ALU_SLT; y = sign_ext16(imm_s); dst = rt_idx_s; illegal = 1'b0;
            end
            OP_ANDI: begin
                ctrl = ALU_AND; y = zero_ext16(imm_s); dst = rt_idx_s; illegal = 1'b0;
            end
            OP_ORI: begin
                ctrl = ALU_OR;  y = zero_ext16(imm_s); dst = rt_idx_s; illegal = 1'b0;
            end
            OP_XORI: begin
                ctrl = ALU_XOR; y = zero_ext16(imm_s); dst = rt_idx_s; illegal = 1'b0;
            end
            OP_LUI: begin
                // lui is performed by the ALU as imm << 16
                ctrl = ALU_SLL; y = zero_ext16(imm_s); sa = 5'd16; dst = rt_idx_s; illegal = 1'b0;
            end
            OP_BEQ, OP_BNE: begin
                ctrl      = ALU_EQ;
                is_branch = 1'b1;
                br_inv    = (opcode_s == OP_BNE);
                illegal   = 1'b0;
            end
            default: begin
                ctrl    = ALU_NONE;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage in front of the ALU: decoder plus a 2-entry skid
// buffer with a registered in_ready. Optional macro: ALU_ISSUE_SHIFTV_EN.
module alu_issue_stage
    import alu_issue_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    input  logic [31:0]        rs_val,
    input  logic [31:0]        rt_val,
    output logic               alu_valid,
    input  logic               alu_ready,
    output logic [3:0]         alu_ctrl,
    output logic signed [31:0] alu_x,
    output logic signed [31:0] alu_y,
    output logic [4:0]         alu_sa,
    output logic [4:0]         dst,
    output logic               is_branch,
    output logic               br_inv,
    output logic               illegal
);

    skid_state_t state_r;
    alu_op_t     main_r;
    alu_op_t     skid_r;
    alu_op_t     dec_op_s;
    logic        alu_valid_r;
    logic        in_ready_r;
    logic        accept_s;
    logic        issue_s;

    alu_issue_dec u_dec (
        .instr     (instr),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .ctrl      (dec_op_s.ctrl),
        .x         (dec_op_s.x),
        .y         (dec_op_s.y),
        .sa        (dec_op_s.sa),
        .dst       (dec_op_s.dst),
        .is_branch (dec_op_s.is_branch),
        .br_inv    (dec_op_s.br_inv),
        .illegal   (dec_op_s.illegal)
    );

    assign accept_s = in_valid && in_ready_r;
    assign issue_s  = alu_valid_r && alu_ready;

    // Skid buffer FSM; valid/ready flags are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= SKID_EMPTY;
            main_r      <= '0;
            skid_r      <= '0;
            alu_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                SKID_EMPTY: begin
                    if (accept_s) begin
                        main_r      <= dec_op_s;
                        state_r     <= SKID_ONE;
                        alu_valid_r <= 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (accept_s && issue_s) begin
                        main_r <= dec_op_s;
                    end else if (accept_s) begin
                        // downstream stalled: park the new op behind main
                        skid_r     <= dec_op_s;
                        state_r    <= SKID_TWO;
                        in_ready_r <= 1'b0;
                    end else if (issue_s) begin
                        state_r     <= SKID_EMPTY;
                        alu_valid_r <= 1'b0;
                    end
                end
                SKID_TWO: begin
                    // in_ready is low here, so only draining is possible
                    if (issue_s) begin
                        main_r     <= skid_r;
                        state_r    <= SKID_ONE;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= SKID_EMPTY;
                    alu_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign alu_valid = alu_valid_r;
    assign alu_ctrl  = main_r.ctrl;
    assign alu_x     = main_r.x;
    assign alu_y     = main_r.y;
    assign alu_sa    = main_r.sa;
    assign dst       = main_r.dst;
    assign is_branch = main_r.is_branch;
    assign br_inv    = main_r.br_inv;
    assign illegal   = main_r.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed steps plus random traffic,
// scored against an instruction-level model and a FIFO of expected ops.
module tb_alu_issue_stage;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        instr = 32'h0;
    logic [31:0]        rs_val = 32'h0;
    logic [31:0]        rt_val = 32'h0;
    logic               alu_valid;
    logic               alu_ready = 1'b0;
    logic [3:0]         alu_ctrl;
    logic signed [31:0] alu_x;
    logic signed [31:0] alu_y;
    logic [4:0]         alu_sa;
    logic [4:0]         dst;
    logic               is_branch;
    logic               br_inv;
    logic               illegal;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  sa;
        logic [4:0]  dst;
        logic        br;
        logic        inv;
        logic        ill;
    } exp_t;

    exp_t q[$];

    logic [5:0] fn_tab [0:17] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                  6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h01,
                                  6'h3F, 6'h08};
    logic [5:0] op_tab [0:10] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h04,
                                  6'h05, 6'h3F, 6'h23};

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_ctrl(alu_ctrl),
        .alu_x(alu_x), .alu_y(alu_y), .alu_sa(alu_sa), .dst(dst),
        .is_branch(is_branch), .br_inv(br_inv), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // What the ALU should be asked to do for one instruction
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        logic [5:0]  op  = ins[31:26];
        logic [5:0]  fn  = ins[5:0];
        logic [15:0] imm = ins[15:0];
        logic [31:0] sx  = {{16{imm[15]}}, imm};
        logic [31:0] zx  = {16'h0000, imm};
        bit vshift = 1'b0;
        e = '{ctrl: 4'hF, x: rs, y: rt, sa: 5'd0, dst: 5'd0, br: 1'b0, inv: 1'b0, ill: 1'b1};
        if (op == 6'h00) begin
            if (fn == 6'h20 || fn == 6'h21) e.ctrl = 4'b0000;
            else if (fn == 6'h22 || fn == 6'h23) e.ctrl = 4'b0001;
            else if (fn == 6'h24) e.ctrl = 4'b0010;
            else if (fn == 6'h25) e.ctrl = 4'b0011;
            else if (fn == 6'h26) e.ctrl = 4'b0101;
            else if (fn == 6'h27) e.ctrl = 4'b0110;
            else if (fn == 6'h2A) e.ctrl = 4'b1100;
            else if (fn == 6'h00) e.ctrl = 4'b0111;
            else if (fn == 6'h02) e.ctrl = 4'b1000;
            else if (fn == 6'h03) e.ctrl = 4'b1001;
`ifdef ALU_ISSUE_SHIFTV_EN
            else if (fn == 6'h04) begin e.ctrl = 4'b0111; vshift = 1'b1; end
            else if (fn == 6'h06) begin e.ctrl = 4'b1000; vshift = 1'b1; end
            else if (fn == 6'h07) begin e.ctrl = 4'b1001; vshift = 1'b1; end
`endif
            if (e.ctrl != 4'hF) begin
                e.ill = 1'b0;
                e.dst = ins[15:11];
                e.sa  = vshift ? rs[4:0] : ins[10:6];
            end
        end else if (op == 6'h08 || op == 6'h09) begin
            e.ctrl = 4'b0000; e.y = sx; e.dst = ins[20:16]; e.ill = 1'b0;
        end else if (op == 6'h0A) begin
            e.ctrl = 4'b1100; e.y = sx; e.dst = ins[20:16]; e.ill = 1'b0;
        end else if (op == 6'h0C || op == 6'h0D || op == 6'h0E) begin
            e.ctrl = (op == 6'h0C) ? 4'b0010 : (op == 6'h0D) ? 4'b0011 : 4'b0101;
            e.y = zx; e.dst = ins[20:16]; e.ill = 1'b0;
        end else if (op == 6'h0F) begin
            e.ctrl = 4'b0111; e.y = zx; e.sa = 5'd16; e.dst = ins[20:16]; e.ill = 1'b0;
        end else if (op == 6'h04 || op == 6'h05) begin
            e.ctrl = 4'b1101; e.br = 1'b1; e.inv = (op == 6'h05); e.ill = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of traffic: drive at negedge, score outputs, update the model queue
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input logic rdy, output logic acc);
        int   sz;
        exp_t e;
        @(negedge clk);
        in_valid = v; instr = ins; rs_val = rs; rt_val = rt; alu_ready = rdy;
        #1;
        sz = q.size();
        chk("alu_valid", 32'(alu_valid), 32'(sz > 0));
        chk("in_ready", 32'(in_ready), 32'(sz < 2));
        if (sz > 0 && rdy) begin
            e = q.pop_front();
            chk("ctrl", 32'(alu_ctrl), 32'(e.ctrl));
            chk("dst", 32'(dst), 32'(e.dst));
            chk("is_branch", 32'(is_branch), 32'(e.br));
            chk("br_inv", 32'(br_inv), 32'(e.inv));
            chk("illegal", 32'(illegal), 32'(e.ill));
            if (!e.ill) begin
                chk("x", alu_x, e.x);
                chk("y", alu_y, e.y);
                chk("sa", 32'(alu_sa), 32'(e.sa));
            end
        end
        acc = v && (sz < 2);
        if (acc) q.push_back(model(ins, rs, rt));
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt, input logic rdy);
        logic acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step(1'b1, ins, rs, rt, rdy, acc);
        chk("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 10 && q.size() > 0; i++) step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, acc);
        chk("drained", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; alu_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        #1;
        chk("rst_alu_valid", 32'(alu_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_x", alu_x, 32'd0);
        chk("rst_y", alu_y, 32'd0);
        chk("rst_sa_dst", {22'd0, alu_sa, dst}, 32'd0);
        chk("rst_flags", {29'd0, is_branch, br_inv, illegal}, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 3))
            0:       w = {6'h00, w[25:6], fn_tab[$urandom_range(0, 17)]};
            1, 2:    w = {op_tab[$urandom_range(0, 10)], w[25:0]};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    initial begin
        logic acc;
        logic [31:0] r1, r2, r3;

        repeat (2) @(negedge clk);
        do_reset();

        // add $3,$1,$2 / addi / lui / bne / illegal opcode / nop / sllv
        send(32'h00221820, 32'd5, 32'd7, 1'b1);
        send(32'h2022FFFF, 32'd10, 32'd0, 1'b1);
        send(32'h3C041234, 32'd0, 32'd0, 1'b1);
        send(32'h14220003, 32'd9, 32'd9, 1'b1);
        send(32'hFC000000, 32'd1, 32'd2, 1'b1);
        send(32'h00000000, 32'd0, 32'd0, 1'b1);
        send(32'h00221804, 32'd3, 32'd1, 1'b1);
        send(32'h3021F00F, 32'hFFFF_FFFF, 32'd0, 1'b1);
        send(32'h2821FFFE, 32'd3, 32'd0, 1'b1);
        drain();

        // Stall with three back-to-back ops: C must be held while the buffer is full
        step(1'b1, 32'h00221820, 32'd1, 32'd2, 1'b0, acc);
        step(1'b1, 32'h00221822, 32'd3, 32'd4, 1'b0, acc);
        step(1'b1, 32'h00221825, 32'd5, 32'd6, 1'b0, acc);
        chk("c_held", 32'(acc), 32'd0);
        step(1'b1, 32'h00221825, 32'd5, 32'd6, 1'b0, acc);
        chk("c_still_held", 32'(acc), 32'd0);
        send(32'h00221825, 32'd5, 32'd6, 1'b1);
        drain();

        // Reset while full: buffered ops must never appear
        step(1'b1, 32'h20030011, 32'd1, 32'd0, 1'b0, acc);
        step(1'b1, 32'h20040022, 32'd2, 32'd0, 1'b0, acc);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, acc);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r1 = rand_instr();
            r2 = $urandom;
            r3 = $urandom;
            step(1'($urandom_range(0, 3) != 0), r1, r2, r3, 1'($urandom_range(0, 2) != 0), acc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
